sram_pb_scrubber: RTL

Read-port manager and error responder for a parity-protected 1R1W SRAM. It muxes client reads with background scrub reads onto the SRAM read port and consumes the SRAM's parity error flag. It logs every failing address, from client or scrub accesses, into a small FIFO for the cache or control logic to drain. It sits directly in front of the SRAM read port; the write port is untouched.

---
 rtl/sram_pb_scrubber_if.sv | 44 ++++
 rtl/sram_pb_scrubber.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sram_pb_scrubber_if.sv
// ---------------------------------------------------------------------------
// sram_pb_scrubber_if
// Purpose : bundles the client read request, the SRAM read-port drive, the
//           SRAM parity flag and the error-log drain port of sram_pb_scrubber.
// Signals : scrub_en, client_read_en/addr, ecc_pb_error, err_ready  (to block)
//           sram_read_en/addr, err_valid/addr/scrub, err_overflow,
//           err_count, sweep_done                                   (from block)
// Modports: slave  - the scrubber itself
//           master - the client / control logic around it
//
// Handshake (error log): err_valid is high whenever the log holds an entry
// and never depends on err_ready. The head entry (err_addr/err_scrub) is
// consumed on the rising edge where err_valid & err_ready are both high;
// err_addr/err_scrub are stable while err_valid is high and not popped.
// ---------------------------------------------------------------------------
interface sram_pb_scrubber_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  scrub_en;
  logic                  client_read_en;
  logic [ADDR_WIDTH-1:0] client_read_addr;
  logic                  sram_read_en;
  logic [ADDR_WIDTH-1:0] sram_read_addr;
  logic                  ecc_pb_error;
  logic                  err_valid;
  logic [ADDR_WIDTH-1:0] err_addr;
  logic                  err_scrub;
  logic                  err_ready;
  logic                  err_overflow;
  logic [15:0]           err_count;
  logic                  sweep_done;

  modport slave (
    input  scrub_en, client_read_en, client_read_addr, ecc_pb_error, err_ready,
    output sram_read_en, sram_read_addr, err_valid, err_addr, err_scrub,
           err_overflow, err_count, sweep_done
  );

  modport master (
    output scrub_en, client_read_en, client_read_addr, ecc_pb_error, err_ready,
    input  sram_read_en, sram_read_addr, err_valid, err_addr, err_scrub,
           err_overflow, err_count, sweep_done
  );
endinterface

// File: rtl/sram_pb_scrubber.sv
// ---------------------------------------------------------------------------
// sram_pb_scrubber
// Purpose : read-port manager for a parity-protected 1R1W SRAM. Muxes client
//           reads (always priority) with paced background scrub reads, and
//           logs the address of every read that raised the parity flag into a
//           small FIFO for control logic to drain.
// Ports   : clk       - single clock, rising edge
//           reset     - asynchronous, active-low
//           bus       - sram_pb_scrubber_if.slave (client, SRAM port, log)
//           dbg_state - current scrub FSM state (0 IDLE, 1 WAIT, 2 ISSUE)
// Params  : SIZE (power of two, >= 2), ADDR_WIDTH, INTERVAL (>= 1),
//           LOG_DEPTH (>= 1, log depth is 2**LOG_DEPTH)
// ---------------------------------------------------------------------------
module sram_pb_scrubber #(
  parameter int SIZE       = 1024,
  parameter int ADDR_WIDTH = $clog2(SIZE),
  parameter int INTERVAL   = 64,
  parameter int LOG_DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  sram_pb_scrubber_if.slave       bus,
  output logic [1:0]              dbg_state
);

  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam int CW    = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [CW-1:0]         RELOAD    = CW'(INTERVAL - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SIZE - 1);
  localparam logic [LOG_DEPTH:0]    FULL_OCC  = (LOG_DEPTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic [ADDR_WIDTH-1:0] r_scrub_addr;
  logic                  r_sweep_done;
  logic                  w_scrub_req;
  logic                  w_scrub_grant;

  // -------------------------------------------------------------------------
  // Scrub FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // -------------------------------------------------------------------------
  // Scrub FSM: next state.
  // The counter reaching 0 in WAIT already makes the read pending in that
  // cycle; ISSUE only holds a read that a client blocked. This is what lets
  // INTERVAL = 1 issue a scrub every cycle and keeps grant spacing exactly
  // INTERVAL when nothing gets in the way.
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (!bus.scrub_en) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_WAIT;
        S_WAIT:  if (r_cnt == '0 && !w_scrub_grant) w_state_nxt = S_ISSUE;
        S_ISSUE: if (w_scrub_grant) w_state_nxt = S_WAIT;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Scrub FSM: outputs. A disabled scrubber never takes the port, even if a
  // read was pending.
  // -------------------------------------------------------------------------
  always_comb begin
    w_scrub_req = 1'b0;
    case (r_state)
      S_WAIT:  w_scrub_req = (r_cnt == '0);
      S_ISSUE: w_scrub_req = 1'b1;
      default: w_scrub_req = 1'b0;
    endcase
    w_scrub_grant = w_scrub_req & bus.scrub_en & ~bus.client_read_en;
  end

  assign dbg_state = r_state;

  // Interval counter: loaded on enable and after each grant, held when
  // disabled so the IDLE state freezes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (bus.scrub_en) begin
      if (r_state == S_IDLE || w_scrub_grant)  r_cnt <= RELOAD;
      else if (r_state == S_WAIT && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
  end

  // Scrub address advances only on a granted read; it survives disables.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scrub_addr <= '0;
      r_sweep_done <= 1'b0;
    end else begin
      r_sweep_done <= w_scrub_grant && (r_scrub_addr == LAST_ADDR);
      if (w_scrub_grant)
        r_scrub_addr <= (r_scrub_addr == LAST_ADDR) ? '0 : r_scrub_addr + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Read-port mux (zero latency)
  // -------------------------------------------------------------------------
  assign bus.sram_read_en   = bus.client_read_en | w_scrub_grant;
  assign bus.sram_read_addr = bus.client_read_en ? bus.client_read_addr : r_scrub_addr;
  assign bus.sweep_done     = r_sweep_done;

  // -------------------------------------------------------------------------
  // Error log FIFO. Entry = {address, came_from_scrub}.
  // A pop in the same cycle frees the slot, so a full log still accepts.
  // -------------------------------------------------------------------------
  logic [ADDR_WIDTH:0]  r_mem [DEPTH];
  logic [LOG_DEPTH-1:0] r_rd_ptr;
  logic [LOG_DEPTH-1:0] r_wr_ptr;
  logic [LOG_DEPTH:0]   r_occ;
  logic                 r_overflow;
  logic [15:0]          r_err_count;
  logic                 w_push_req;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_push;
  logic                 w_drop;

  assign w_push_req = bus.ecc_pb_error & bus.sram_read_en;
  assign w_pop      = (r_occ != '0) & bus.err_ready;
  assign w_full     = (r_occ == FULL_OCC);
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;

  // Storage needs no reset: nothing is read while the log is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.sram_read_addr, w_scrub_grant};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Counts every detected error, including dropped ones; saturates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow  <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (w_drop) r_overflow <= 1'b1;
      if (w_push_req && r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
    end
  end

  // Head is forced to zero while empty so the outputs read 0 out of reset.
  assign bus.err_valid    = (r_occ != '0);
  assign bus.err_addr     = bus.err_valid ? r_mem[r_rd_ptr][ADDR_WIDTH:1] : '0;
  assign bus.err_scrub    = bus.err_valid ? r_mem[r_rd_ptr][0] : 1'b0;
  assign bus.err_overflow = r_overflow;
  assign bus.err_count    = r_err_count;

endmodule
